adder_stim_checker: RTL and testbench

//  Initiator/checker for the registered 4+4->8 adder (`adder`): drives exhaustive operand pairs
//  on op_a/op_b, receives the registered sum on sum_in, and compares it against an internal

---
 rtl/adder_stim_checker.sv | 147 ++++++++++++++
 tb/tb_adder_stim_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_stim_checker.sv
// Stimulus generator and checker for a registered adder: walks every operand pair,
// compares the returned sum against a delayed expected-value pipeline, reports the result.
module adder_stim_checker #(
  parameter int A_W   = 4,
  parameter int C_W   = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [A_W-1:0]   op_a,
  output logic [A_W-1:0]   op_b,
  input  logic [C_W-1:0]   sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [A_W-1:0]   first_err_a,
  output logic [A_W-1:0]   first_err_b,
  output logic [C_W-1:0]   first_err_sum
);
  localparam int I_W = 2 * A_W;
  localparam int D_W = $clog2(LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
    logic [C_W-1:0] exp;
  } exp_t;

  state_t           state;
  logic [I_W-1:0]   idx;
  logic [I_W-1:0]   idx_nxt;
  logic [D_W-1:0]   dcnt;
  logic [LAT:0]     vld_pipe;
  exp_t [LAT:0]     dat_pipe;
  exp_t             vec0, vec_nxt;
  logic             mismatch;

  function automatic exp_t mk_vec(input logic [I_W-1:0] i);
    exp_t v;
    v.a   = i[A_W-1:0];
    v.b   = i[I_W-1:A_W];
    v.exp = C_W'(v.a) + C_W'(v.b);
    return v;
  endfunction

  assign idx_nxt  = idx + I_W'(1);
  assign vec0     = mk_vec('0);
  assign vec_nxt  = mk_vec(idx_nxt);
  // Stage LAT holds the vector whose sum is on sum_in this cycle.
  assign mismatch = vld_pipe[LAT] && (sum_in != dat_pipe[LAT].exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      dcnt          <= '0;
      vld_pipe      <= '0;
      dat_pipe      <= '0;
      op_a          <= '0;
      op_b          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_sum <= '0;
    end else begin
      for (int k = 1; k <= LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
      vld_pipe[0] <= 1'b0;

      if (!abort && mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (err_count == '0) begin
          first_err_a   <= dat_pipe[LAT].a;
          first_err_b   <= dat_pipe[LAT].b;
          first_err_sum <= sum_in;
        end
      end

      if (abort) begin
        state    <= IDLE;
        vld_pipe <= '0;
        op_a     <= '0;
        op_b     <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state         <= DRIVE;
              idx           <= '0;
              op_a          <= vec0.a;
              op_b          <= vec0.b;
              vld_pipe[0]   <= 1'b1;
              dat_pipe[0]   <= vec0;
              busy          <= 1'b1;
              done          <= 1'b0;
              pass          <= 1'b0;
              err_count     <= '0;
              first_err_a   <= '0;
              first_err_b   <= '0;
              first_err_sum <= '0;
            end
          end
          DRIVE: begin
            // No wrap after the all-ones vector: stop issuing and let the pipe drain.
            if (idx == '1) begin
              state <= DRAIN;
              dcnt  <= '0;
              op_a  <= '0;
              op_b  <= '0;
            end else begin
              idx         <= idx_nxt;
              op_a        <= vec_nxt.a;
              op_b        <= vec_nxt.b;
              vld_pipe[0] <= 1'b1;
              dat_pipe[0] <= vec_nxt;
            end
          end
          DRAIN: begin
            if (dcnt == D_W'(LAT)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0);
            end else begin
              dcnt <= dcnt + D_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adder_stim_checker.sv
// Two checkers (LAT=1 wide counter, LAT=2 narrow counter) beside behavioural adders with
// selectable faults; run summaries are scoreboarded against an exhaustive reference sweep.
module tb_adder_stim_checker;
  logic clk = 1'b0;
  logic rst_n, start, abort;
  always #5 clk = ~clk;

  logic [3:0]  op_a1, op_b1, fa1, fb1;
  logic [7:0]  sum1, fs1;
  logic        busy1, done1, pass1;
  logic [15:0] err1;

  logic [3:0]  op_a2, op_b2, fa2, fb2;
  logic [7:0]  sum2, sum2_s0, fs2;
  logic        busy2, done2, pass2;
  logic [3:0]  err2;

  int mode1 = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cnt;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [7:0] fs;
    logic       pass;
  } res_t;

  res_t q1[$];
  res_t q2[$];

  adder_stim_checker #(.A_W(4), .C_W(8), .LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a1), .op_b(op_b1), .sum_in(sum1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_sum(fs1));

  adder_stim_checker #(.A_W(4), .C_W(8), .LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a2), .op_b(op_b2), .sum_in(sum2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_sum(fs2));

  // mode 0 correct, 1 bit0 stuck-at-0, 2 inverted, 3 single bad vector (a=7,b=11)
  function automatic logic [7:0] faulty(input logic [3:0] a, input logic [3:0] b, input int mode);
    logic [7:0] s;
    s = 8'(a) + 8'(b);
    case (mode)
      1: s = s & 8'hFE;
      2: s = ~s;
      3: if (a == 4'd7 && b == 4'd11) s = s ^ 8'h40;
      default: ;
    endcase
    return s;
  endfunction

  always @(posedge clk) sum1 <= faulty(op_a1, op_b1, mode1);
  always @(posedge clk) begin
    sum2_s0 <= faulty(op_a2, op_b2, 2);
    sum2    <= sum2_s0;
  end

  function automatic res_t ref_run(input int mode, input int cmax);
    res_t r;
    r.cnt = 0; r.fa = '0; r.fb = '0; r.fs = '0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      logic [7:0] got, want;
      a = 4'(i % 16);
      b = 4'(i / 16);
      want = 8'((i % 16) + (i / 16));
      got = faulty(a, b, mode);
      if (got != want) begin
        if (r.cnt == 0) begin r.fa = a; r.fb = b; r.fs = got; end
        if (r.cnt < cmax) r.cnt++;
      end
    end
    r.pass = (r.cnt == 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each rising done pops the expected summary for that run.
  logic d1_prev = 1'b0, d2_prev = 1'b0;
  always begin
    @(posedge clk); #1;
    if (done1 && !d1_prev) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done1: got done expected none");
      end else begin
        res_t r;
        r = q1.pop_front();
        chk("err_count1", 32'(err1), r.cnt);
        chk("pass1", 32'(pass1), 32'(r.pass));
        chk("first_a1", 32'(fa1), 32'(r.fa));
        chk("first_b1", 32'(fb1), 32'(r.fb));
        chk("first_sum1", 32'(fs1), 32'(r.fs));
      end
    end
    if (done2 && !d2_prev) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done2: got done expected none");
      end else begin
        res_t r;
        r = q2.pop_front();
        chk("err_count2", 32'(err2), r.cnt);
        chk("pass2", 32'(pass2), 32'(r.pass));
        chk("first_a2", 32'(fa2), 32'(r.fa));
        chk("first_b2", 32'(fb2), 32'(r.fb));
        chk("first_sum2", 32'(fs2), 32'(r.fs));
      end
    end
    d1_prev = done1;
    d2_prev = done2;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy1), 0);
    chk({tag, "_done"}, 32'(done1), 0);
    chk({tag, "_pass"}, 32'(pass1), 0);
    chk({tag, "_ops"}, 32'({op_b1, op_a1}), 0);
    chk({tag, "_err"}, 32'(err1), 0);
    chk({tag, "_first"}, 32'({fa1, fb1, fs1}), 0);
    chk({tag, "_busy2"}, 32'(busy2), 0);
    chk({tag, "_err2"}, 32'(err2), 0);
  endtask

  task automatic run(input int mode, input int restart_at, input int abort_at, input int reset_at);
    int c1, c2;
    c1 = -1; c2 = -1;
    mode1 = mode;
    if (abort_at < 0 && reset_at < 0) begin
      q1.push_back(ref_run(mode, 65535));
      q2.push_back(ref_run(2, 15));
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_busy", 32'(busy1), 1);
    chk("start_done_clr", 32'(done1), 0);
    chk("vec0_ops", 32'({op_b1, op_a1}), 0);
    for (int k = 1; k <= 600; k++) begin
      start = (k == restart_at);
      abort = (k == abort_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (k == abort_at) begin
        chk("abort_busy", 32'(busy1), 0);
        chk("abort_done", 32'(done1), 0);
        chk("abort_ops", 32'({op_b1, op_a1}), 0);
        chk("abort_busy2", 32'(busy2), 0);
        repeat (300) @(posedge clk);
        #1 chk("abort_no_done", 32'(done1), 0);
        return;
      end
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1 chk_zero("reset_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == 50)  chk("vec50_ops", 32'({op_b1, op_a1}), 50);
      if (k == 120) chk("vec120_ops", 32'({op_b1, op_a1}), 120);
      if (k == 200) chk("drive_busy", 32'(busy1), 1);
      if (done1 && c1 < 0) c1 = k;
      if (done2 && c2 < 0) c2 = k;
      if (c1 >= 0 && c2 >= 0) break;
    end
    chk("done_edge_lat1", 32'(c1), 258);
    chk("done_edge_lat2", 32'(c2), 259);
    chk("done_not_busy", 32'(busy1), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_start_low", 32'(busy1), 0);

    run(0, -1, -1, -1);   // clean run
    run(1, -1, -1, -1);   // stuck bit0, restart from DONE
    run(3, 100, -1, -1);  // single bad vector, start mid-run ignored
    run(0, -1, 50, -1);   // abort
    run(0, -1, -1, -1);
    run(1, -1, -1, 70);   // reset mid-run
    run(0, -1, -1, -1);
    run($urandom_range(0, 3), $urandom_range(1, 250), -1, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
